// File: rtl/rom_stream_reader.sv
// Burst reader for an asynchronous-read ROM: walks an address range on a start
// command and presents each captured byte on a registered valid/ready stream.
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_ce,
    output logic                  rom_read_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE    = 1;
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic                  state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic in_stream;
    logic slot_free;
    logic fetch;
    logic complete;

    // The output register can take a new word when it is empty or being drained this cycle.
    assign in_stream = (state_q == ST_STREAM);
    assign slot_free = !out_valid_q || out_ready;
    assign fetch     = in_stream && (remaining_q != '0) && slot_free && !abort;
    assign complete  = in_stream && (remaining_q == '0) && slot_free && !abort;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start) begin
                cur_addr_d  = start_addr;
                remaining_d = (length == '0) ? FULL_COUNT : {1'b0, length};
                state_d     = ST_STREAM;
                busy_d      = 1'b1;
            end
        end else if (abort) begin
            // Any word still held in the output register is discarded.
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (fetch) begin
                out_data_d  = rom_data;
                out_valid_d = 1'b1;
                cur_addr_d  = cur_addr_q + ADDR_ONE;
                remaining_d = remaining_q - REM_ONE;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (complete) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_address = cur_addr_q;
    assign rom_ce      = fetch;
    assign rom_read_en = fetch;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a behavioural ROM plus an expected-byte queue per
// burst, with random backpressure and directed abort/reset/wrap scenarios.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] length;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] rom_address;
    logic       rom_ce;
    logic       rom_read_en;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    logic [7:0] rom [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_address];

    rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rom_address(rom_address),
        .rom_ce     (rom_ce),
        .rom_read_en(rom_read_en),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom_pattern();
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    endtask

    // stall_pct: 0 = always ready, >0 = random percentage of not-ready cycles,
    // -1 = ready low for three cycles after the first word appears.
    task automatic run_burst(input logic [7:0] sa, input int n_words, input int stall_pct,
                             input int abort_after, input bit dup_start);
        logic [7:0] exp_q[$];
        logic [7:0] held;
        logic [7:0] exp_addr;
        int  acc = 0, hs = 0, cyc = 0;
        bit  finished = 0, last_hs = 0, aborting = 0, prev_stall = 0;

        held = '0;
        for (int k = 0; k < n_words; k++) exp_q.push_back(rom[(int'(sa) + k) % 256]);

        start = 1'b1; start_addr = sa; length = 8'(n_words);
        out_ready = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        while (!finished && cyc < n_words * 20 + 50) begin
            if (aborting) begin
                check("abort_valid", 32'(out_valid), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_no_done", 32'(done), 0);
                finished = 1;
            end else if (last_hs) begin
                check("done_pulse", 32'(done), 1);
                check("done_busy", 32'(busy), 0);
                check("done_valid", 32'(out_valid), 0);
                finished = 1;
            end else begin
                check("done_early", 32'(done), 0);
                check("busy_burst", 32'(busy), 1);
                if (prev_stall) begin
                    check("stall_valid_hold", 32'(out_valid), 1);
                    check("stall_data_hold", 32'(out_data), 32'(held));
                end
                if (stall_pct < 0) out_ready = !(cyc >= 1 && cyc <= 3);
                else if (stall_pct == 0) out_ready = 1'b1;
                else out_ready = ($urandom_range(99) >= 32'(stall_pct));
                start = dup_start && (cyc == 2);
                start_addr = sa ^ 8'h5A;
                length = 8'd3;
                aborting = (abort_after >= 0) && (hs == abort_after);
                abort = aborting;
                if (aborting) out_ready = 1'b0;
                #1;
                if (cyc == 0 && !aborting) begin
                    check("first_valid_low", 32'(out_valid), 0);
                    check("first_fetch", 32'(rom_ce), 1);
                end
                if (stall_pct == 0 && !aborting && cyc >= 1)
                    check("back_to_back", 32'(out_valid), 1);
                check("re_eq_ce", 32'(rom_read_en), 32'(rom_ce));
                if (aborting) check("abort_no_fetch", 32'(rom_ce), 0);
                if (rom_ce) begin
                    exp_addr = sa + 8'(acc);
                    check("rom_addr", 32'(rom_address), 32'(exp_addr));
                    check("overfetch", 32'(acc < n_words), 1);
                    acc++;
                end
                prev_stall = 0;
                if (out_valid && !out_ready && !aborting) begin
                    check("stall_no_fetch", 32'(rom_ce), 0);
                    held = out_data;
                    prev_stall = 1;
                end
                if (out_valid && out_ready) begin
                    check("out_data", 32'(out_data), 32'(exp_q[hs]));
                    hs++;
                    if (hs == n_words) last_hs = 1;
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        if (!finished) check("timeout", 0, 1);
        #1;
        check("idle_ce", 32'(rom_ce), 0);
        if (finished && !aborting) begin
            @(posedge clk); #1;
            check("done_once", 32'(done), 0);
            check("idle_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        fill_rom_pattern();
        reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
        abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ce", 32'(rom_ce), 0);
        check("rst_re", 32'(rom_read_en), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_addr", 32'(rom_address), 0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        run_burst(8'h10, 4, 0, -1, 0);
        run_burst(8'h10, 4, -1, -1, 0);
        run_burst(8'hFE, 256, 0, -1, 0);

        fill_rom_random();
        for (int t = 0; t < 5; t++)
            run_burst(8'($urandom), int'($urandom_range(1, 20)), 40, -1, 0);

        run_burst(8'($urandom), 10, 30, 3, 0);
        run_burst(8'h40, 1, 0, -1, 0);
        run_burst(8'h20, 6, 0, -1, 1);
        run_burst(8'h80, 5, 50, -1, 1);

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_valid", 32'(out_valid), 0);

        fill_rom_pattern();
        start = 1'b1; start_addr = 8'h10; length = 8'd4; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", 32'(out_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 0);
        check("async_busy", 32'(busy), 0);
        check("async_ce", 32'(rom_ce), 0);
        check("async_re", 32'(rom_read_en), 0);
        check("async_done", 32'(done), 0);
        check("async_addr", 32'(rom_address), 0);
        @(posedge clk); #1;
        check("reset_hold_done", 32'(done), 0);
        #2 reset_n = 1'b1;
        out_ready = 1'b0;
        #1;
        run_burst(8'h10, 4, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
